// File: rtl/runner_pkg.sv
// runner_pkg: definitions shared between the input decoder and the
// jump motion controller.
//   - MV_* : one-cycle movement command codes from the input decoder
//   - motion_state_t : vertical motion state encoding (also exported
//     on the controller's state_dbg port)
package runner_pkg;

   localparam logic [2:0] MV_NONE   = 3'b000;
   localparam logic [2:0] MV_BIG    = 3'b001;
   localparam logic [2:0] MV_SMALL  = 3'b010;
   localparam logic [2:0] MV_CROUCH = 3'b011;
   localparam logic [2:0] MV_DROP   = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CROUCH = 3'd1,
      ST_RISE   = 3'd2,
      ST_HANG   = 3'd3,
      ST_FALL   = 3'd4,
      ST_DROP   = 3'd5,
      ST_LAND   = 3'd6
   } motion_state_t;

   // True for the states in which the runner is off the ground.
   function automatic logic is_airborne(input motion_state_t s);
      return (s == ST_RISE) || (s == ST_HANG) || (s == ST_FALL) || (s == ST_DROP);
   endfunction

endpackage

// File: rtl/y_stepper.sv
// y_stepper: saturating one-step move of the height offset.
//   y        : current height
//   step     : amount to move
//   dir      : 1 = move up towards limit (ceiling), 0 = move down towards limit (floor)
//   limit    : ceiling when rising, floor when falling
//   next_y   : y moved by step, clamped at limit
//   hit_limit: next_y equals limit (the clamp engaged or the step landed exactly on it)
// Arithmetic is done one bit wider than Y_W so neither direction can wrap.
module y_stepper #(
   parameter int Y_W = 7
) (
   input  logic [Y_W-1:0] y,
   input  logic [Y_W-1:0] step,
   input  logic           dir,
   input  logic [Y_W-1:0] limit,
   output logic [Y_W-1:0] next_y,
   output logic           hit_limit
);

   logic [Y_W:0] sum;
   logic [Y_W:0] diff;

   always_comb begin
      sum       = {1'b0, y} + {1'b0, step};
      diff      = {1'b0, y} - {1'b0, step};
      next_y    = y;
      hit_limit = 1'b0;
      if (dir) begin
         if (sum >= {1'b0, limit}) begin
            next_y    = limit;
            hit_limit = 1'b1;
         end else begin
            next_y = sum[Y_W-1:0];
         end
      end else begin
         // diff[Y_W] set means the subtraction borrowed (went below zero)
         if (diff[Y_W] || (diff[Y_W-1:0] <= limit)) begin
            next_y    = limit;
            hit_limit = 1'b1;
         end else begin
            next_y = diff[Y_W-1:0];
         end
      end
   end

endmodule

// File: rtl/jump_motion_controller.sv
// jump_motion_controller: sequences the runner's vertical motion.
// Turns one-cycle movement codes into a frame-stepped height offset,
// a crouch flag, an airborne flag and a one-cycle landing pulse.
// Height only changes on cycles where frame_tick is high.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-low reset
//   movement   : command code (MV_* in runner_pkg)
//   frame_tick : one-cycle pulse per display frame
//   y_offset   : height above ground, 0 = on ground
//   crouching  : high in CROUCH
//   airborne   : high in RISE, HANG, FALL, DROP
//   land       : high for the single LAND cycle
//   state_dbg  : current state encoding
//
// Build option: define DOUBLE_JUMP_EN to accept one extra jump per
// airborne episode (from RISE, HANG or FALL). Without it airborne jump
// codes are ignored.
module jump_motion_controller
   import runner_pkg::*;
#(
   parameter int Y_W        = 7,
   parameter int BIG_H      = 48,
   parameter int SMALL_H    = 24,
   parameter int RISE_STEP  = 4,
   parameter int FALL_STEP  = 4,
   parameter int DROP_STEP  = 12,
   parameter int HANG_TICKS = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [2:0]     movement,
   input  logic           frame_tick,
   output logic [Y_W-1:0] y_offset,
   output logic           crouching,
   output logic           airborne,
   output logic           land,
   output logic [2:0]     state_dbg
);

   localparam int Y_MAX = (2 ** Y_W) - 1;

   // Constants clamped to the representable range so they fit Y_W bits.
   localparam logic [Y_W-1:0] BIG_T  = Y_W'((BIG_H     > Y_MAX) ? Y_MAX : BIG_H);
   localparam logic [Y_W-1:0] SMALL_T = Y_W'((SMALL_H  > Y_MAX) ? Y_MAX : SMALL_H);
   localparam logic [Y_W-1:0] RISE_S = Y_W'((RISE_STEP > Y_MAX) ? Y_MAX : RISE_STEP);
   localparam logic [Y_W-1:0] FALL_S = Y_W'((FALL_STEP > Y_MAX) ? Y_MAX : FALL_STEP);
   localparam logic [Y_W-1:0] DROP_S = Y_W'((DROP_STEP > Y_MAX) ? Y_MAX : DROP_STEP);

   localparam int HC_W = (HANG_TICKS > 1) ? $clog2(HANG_TICKS) : 1;
   localparam logic [HC_W-1:0] HANG_INIT = HC_W'(HANG_TICKS - 1);

   motion_state_t   state_reg,    state_next;
   logic [Y_W-1:0]  y_reg,        y_next;
   logic [Y_W-1:0]  target_reg,   target_next;
   logic [HC_W-1:0] hang_cnt_reg, hang_cnt_next;

   logic [Y_W-1:0]  step_sel;
   logic            dir_sel;
   logic [Y_W-1:0]  limit_sel;
   logic [Y_W-1:0]  stepped_y;
   logic            stepped_hit;

   // Height plus offset, saturating at the top of the Y_W range.
   function automatic logic [Y_W-1:0] sat_add(input logic [Y_W-1:0] a,
                                              input logic [Y_W-1:0] b);
      logic [Y_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[Y_W] ? {Y_W{1'b1}} : s[Y_W-1:0];
   endfunction

   // One stepper shared by all moving states: only one of them is active.
   always_comb begin
      step_sel  = RISE_S;
      dir_sel   = 1'b1;
      limit_sel = target_reg;
      if (state_reg == ST_FALL) begin
         step_sel  = FALL_S;
         dir_sel   = 1'b0;
         limit_sel = '0;
      end else if (state_reg == ST_DROP) begin
         step_sel  = DROP_S;
         dir_sel   = 1'b0;
         limit_sel = '0;
      end
   end

   y_stepper #(
      .Y_W (Y_W)
   ) u_y_stepper (
      .y         (y_reg),
      .step      (step_sel),
      .dir       (dir_sel),
      .limit     (limit_sel),
      .next_y    (stepped_y),
      .hit_limit (stepped_hit)
   );

`ifdef DOUBLE_JUMP_EN
   logic used_reg, used_next;
   logic extra_jump;

   // A second jump is only taken from the flight phases and only once;
   // a drop code is never a jump code, so drop keeps its priority.
   assign extra_jump = ((movement == MV_BIG) || (movement == MV_SMALL)) && !used_reg &&
                       ((state_reg == ST_RISE) || (state_reg == ST_HANG) ||
                        (state_reg == ST_FALL));
`endif

   always_comb begin
      state_next    = state_reg;
      y_next        = y_reg;
      target_next   = target_reg;
      hang_cnt_next = hang_cnt_reg;
`ifdef DOUBLE_JUMP_EN
      used_next     = used_reg;
`endif
      unique case (state_reg)
         ST_IDLE: begin
            // Command wins over a same-cycle frame_tick; no step from ground.
            if (movement == MV_BIG) begin
               state_next  = ST_RISE;
               target_next = sat_add(y_reg, BIG_T);
            end else if (movement == MV_SMALL) begin
               state_next  = ST_RISE;
               target_next = sat_add(y_reg, SMALL_T);
            end else if (movement == MV_CROUCH) begin
               state_next = ST_CROUCH;
            end
         end
         ST_CROUCH: begin
            if (movement != MV_CROUCH) begin
               state_next = ST_IDLE;
            end
         end
         ST_RISE: begin
            if (movement == MV_DROP) begin
               state_next = ST_DROP;
            end else if (frame_tick) begin
               y_next = stepped_y;
               if (stepped_hit) begin
                  state_next    = ST_HANG;
                  hang_cnt_next = HANG_INIT;
               end
            end
         end
         ST_HANG: begin
            if (movement == MV_DROP) begin
               state_next = ST_DROP;
            end else if (frame_tick) begin
               if (hang_cnt_reg == '0) begin
                  state_next = ST_FALL;
               end else begin
                  hang_cnt_next = hang_cnt_reg - 1'b1;
               end
            end
         end
         ST_FALL: begin
            if (movement == MV_DROP) begin
               state_next = ST_DROP;
            end else if (frame_tick) begin
               y_next = stepped_y;
               if (stepped_hit) begin
                  state_next = ST_LAND;
               end
            end
         end
         ST_DROP: begin
            // Further drop codes are meaningless here and are ignored.
            if (frame_tick) begin
               y_next = stepped_y;
               if (stepped_hit) begin
                  state_next = ST_LAND;
               end
            end
         end
         ST_LAND: begin
            state_next = ST_IDLE;
`ifdef DOUBLE_JUMP_EN
            used_next  = 1'b0;
`endif
         end
         default: begin
            state_next = ST_IDLE;
            y_next     = '0;
         end
      endcase
`ifdef DOUBLE_JUMP_EN
      // Accepted extra jump overrides any phase change of this cycle but
      // the same-cycle height step (already in y_next) still applies.
      if (extra_jump) begin
         state_next  = ST_RISE;
         target_next = sat_add(y_reg, (movement == MV_BIG) ? BIG_T : SMALL_T);
         used_next   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         y_reg        <= '0;
         target_reg   <= '0;
         hang_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         y_reg        <= y_next;
         target_reg   <= target_next;
         hang_cnt_reg <= hang_cnt_next;
      end
   end

`ifdef DOUBLE_JUMP_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         used_reg <= 1'b0;
      end else begin
         used_reg <= used_next;
      end
   end
`endif

   // Outputs come from registered state only.
   assign y_offset  = y_reg;
   assign crouching = (state_reg == ST_CROUCH);
   assign airborne  = is_airborne(state_reg);
   assign land      = (state_reg == ST_LAND);
   assign state_dbg = state_reg;

endmodule
